neural_stream_packer: RTL and testbench



---
 rtl/neural_stream_pkg.sv | 29 ++
 rtl/neural_stream_fifo_sync.sv | 57 +++++
 rtl/neural_stream_packer.sv | 154 +++++++++++++++
 tb/tb_neural_stream_packer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neural_stream_pkg.sv
// Shared types and parameter helpers for the neural stream packer.
// Holds the FSM state type, lane-ratio derivation and parameter legality checks.
package neural_stream_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_DROP = 2'd1,
      ST_STOP = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic int unsigned ratio_of(input int unsigned in_w, input int unsigned out_w);
      return (in_w == 0) ? 0 : out_w / in_w;
   endfunction

   function automatic int unsigned lane_w_of(input int unsigned ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   function automatic bit params_ok(input int unsigned in_w, input int unsigned out_w,
                                    input int unsigned depth);
      int unsigned r;
      r = ratio_of(in_w, out_w);
      return (in_w != 0) && ((out_w % in_w) == 0) &&
             (r == 1 || r == 2 || r == 4 || r == 8) &&
             (depth >= 4) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/neural_stream_fifo_sync.sv
// Single-clock pointer FIFO with registered read data and a word-count level.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module neural_stream_fifo_sync #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] rd_data_q, rd_data_d;
   logic         push, pop;

   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      level     = wr_ptr_q - rd_ptr_q;
      push      = wr_en & ~full & ~clr;
      pop       = rd_en & ~empty & ~clr;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
      if (clr) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         rd_data_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/neural_stream_packer.sv
// Packs IN_W-bit samples into OUT_W-bit host words with frame-aware flushing,
// overflow policy, drop counting and an orderly stop/EOF sequence.
module neural_stream_packer
   import neural_stream_pkg::*;
#(
   parameter int unsigned IN_W       = 16,
   parameter int unsigned OUT_W      = 32,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned DROP_FRAME = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                    bus_clk,
   input  logic                    reset,
   input  logic [IN_W-1:0]         in_data,
   input  logic                    in_wen,
   input  logic                    in_sof,
   input  logic                    stop_req,
   input  logic                    user_r_open,
   input  logic                    user_r_rden,
   output logic                    user_r_empty,
   output logic [OUT_W-1:0]        user_r_data,
   output logic                    user_r_eof,
   output logic [$clog2(DEPTH):0]  fill_level,
   output logic                    overflow,
   output logic [CNT_W-1:0]        drop_count
);

   localparam int unsigned RATIO  = ratio_of(IN_W, OUT_W);
   localparam int unsigned LANE_W = lane_w_of(RATIO);

   if (!params_ok(IN_W, OUT_W, DEPTH)) begin : g_bad_params
      $error("neural_stream_packer: illegal IN_W/OUT_W/DEPTH combination");
   end

   state_e              state_q, state_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [OUT_W-1:0]    part_q, part_d;
   logic                push_vld_q, push_vld_d;
   logic                push_drop_q, push_drop_d;
   logic [OUT_W-1:0]    push_word_q, push_word_d;
   logic                overflow_q, overflow_d;
   logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

   logic                clr, discard, reject, drop_evt, fifo_wr, accept, lane_last;
   logic                fifo_full, fifo_empty;
   logic [OUT_W-1:0]    part_ins, sof_fresh;

   always_comb begin
      clr       = reset | ~user_r_open;
      // Words generated in DROP, or pending while the FSM sits in DROP, never reach the FIFO.
      discard   = push_drop_q | (state_q == ST_DROP);
      reject    = push_vld_q & ~discard & fifo_full & ~clr;
      drop_evt  = push_vld_q & (discard | fifo_full) & ~clr;
      fifo_wr   = push_vld_q & ~discard & ~fifo_full & ~clr;
      accept    = in_wen & ~stop_req & ((state_q == ST_RUN) || (state_q == ST_DROP));
      lane_last = (lane_q == LANE_W'(RATIO - 1));
      part_ins  = part_q;
      part_ins[lane_q * IN_W +: IN_W] = in_data;
      sof_fresh = '0;
      sof_fresh[IN_W-1:0] = in_data;

      state_d     = state_q;
      lane_d      = lane_q;
      part_d      = part_q;
      push_vld_d  = 1'b0;
      push_drop_d = 1'b0;
      push_word_d = '0;
      overflow_d  = overflow_q | reject;
      drop_cnt_d  = (drop_evt && (drop_cnt_q != '1)) ? drop_cnt_q + 1'b1 : drop_cnt_q;

      if (clr) begin
         state_d = ST_RUN;
         lane_d  = '0;
         part_d  = '0;
      end else if (stop_req && (state_q != ST_DONE)) begin
         state_d = ST_STOP;
         lane_d  = '0;
         part_d  = '0;
         if (lane_q != '0) begin
            push_vld_d  = 1'b1;
            push_word_d = part_q;
            push_drop_d = (state_q == ST_DROP);
         end
      end else begin
         unique case (state_q)
            ST_RUN:  if (reject && (DROP_FRAME != 0)) state_d = ST_DROP;
            ST_DROP: if (accept && in_sof) state_d = ST_RUN;
            ST_STOP: if (!push_vld_q && fifo_empty) state_d = ST_DONE;
            default: state_d = state_q;
         endcase
         if (accept) begin
            if (in_sof && (lane_q != '0)) begin
               push_vld_d  = 1'b1;
               push_word_d = part_q;
               push_drop_d = (state_q == ST_DROP);
               part_d      = sof_fresh;
               lane_d      = LANE_W'(1);
            end else if (lane_last) begin
               push_vld_d  = 1'b1;
               push_word_d = part_ins;
               push_drop_d = (state_q == ST_DROP);
               part_d      = '0;
               lane_d      = '0;
            end else begin
               part_d = part_ins;
               lane_d = lane_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge bus_clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         lane_q      <= '0;
         part_q      <= '0;
         push_vld_q  <= 1'b0;
         push_drop_q <= 1'b0;
         push_word_q <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         part_q      <= part_d;
         push_vld_q  <= push_vld_d;
         push_drop_q <= push_drop_d;
         push_word_q <= push_word_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   neural_stream_fifo_sync #(
      .W     (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (bus_clk),
      .clr     (clr),
      .wr_en   (fifo_wr),
      .wr_data (push_word_q),
      .rd_en   (user_r_rden),
      .rd_data (user_r_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fill_level)
   );

   assign user_r_empty = fifo_empty | (state_q == ST_DONE);
   assign user_r_eof   = (state_q == ST_DONE);
   assign overflow     = overflow_q;
   assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_neural_stream_packer.sv
// Bench for neural_stream_packer: two DEPTH=4 instances (frame-drop and word-drop policy)
// share stimulus; expected host words are queued as samples are driven.
module tb_neural_stream_packer;

   logic        clk = 1'b0;
   logic        reset, in_wen, in_sof, stop_req, user_r_open, user_r_rden;
   logic [15:0] in_data;

   logic        m_empty, m_eof, m_ovf;
   logic [31:0] m_data;
   logic [2:0]  m_level;
   logic [15:0] m_drop;
   logic        n_empty, n_eof, n_ovf;
   logic [31:0] n_data;
   logic [2:0]  n_level;
   logic [1:0]  n_drop;

   logic        sel;
   logic        s_empty;
   logic [31:0] s_data;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [15:0] data;
      logic        sof;
      logic        push;
      logic [31:0] word;
   } vec_t;
   vec_t vecs[7];

   always #5 clk = ~clk;

   neural_stream_packer #(
      .IN_W(16), .OUT_W(32), .DEPTH(4), .DROP_FRAME(1), .CNT_W(16)
   ) u_dut (
      .bus_clk(clk), .reset(reset), .in_data(in_data), .in_wen(in_wen), .in_sof(in_sof),
      .stop_req(stop_req), .user_r_open(user_r_open), .user_r_rden(user_r_rden),
      .user_r_empty(m_empty), .user_r_data(m_data), .user_r_eof(m_eof),
      .fill_level(m_level), .overflow(m_ovf), .drop_count(m_drop)
   );

   neural_stream_packer #(
      .IN_W(16), .OUT_W(32), .DEPTH(4), .DROP_FRAME(0), .CNT_W(2)
   ) u_dut_nf (
      .bus_clk(clk), .reset(reset), .in_data(in_data), .in_wen(in_wen), .in_sof(in_sof),
      .stop_req(stop_req), .user_r_open(user_r_open), .user_r_rden(user_r_rden),
      .user_r_empty(n_empty), .user_r_data(n_data), .user_r_eof(n_eof),
      .fill_level(n_level), .overflow(n_ovf), .drop_count(n_drop)
   );

   assign s_empty = sel ? n_empty : m_empty;
   assign s_data  = sel ? n_data  : m_data;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      user_r_open = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic send(input logic [15:0] d, input logic sof);
      in_data = d;
      in_sof  = sof;
      in_wen  = 1'b1;
      tick();
      in_wen  = 1'b0;
      in_sof  = 1'b0;
   endtask

   function automatic logic [31:0] word_of(input int k);
      logic [15:0] lo, hi;
      lo = 16'hA000 + 16'(k);
      hi = 16'hB000 + 16'(k);
      return {hi, lo};
   endfunction

   task automatic send_word(input int k, input logic sof, input logic expect_push);
      logic [31:0] w;
      w = word_of(k);
      if (expect_push) exp_q.push_back(w);
      send(w[15:0], sof);
      send(w[31:16], 1'b0);
   endtask

   task automatic rd_one(input string nm);
      int k;
      logic [31:0] e;
      k = 0;
      while (s_empty && k < 20) begin
         tick();
         k++;
      end
      if (s_empty) begin
         checks++;
         errors++;
         $display("FAIL %s: got empty=1 expected data available within 20 cycles", nm);
      end else begin
         user_r_rden = 1'b1;
         tick();
         user_r_rden = 1'b0;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got word %0h expected no word", nm, s_data);
         end else begin
            e = exp_q.pop_front();
            chk(nm, {32'h0, s_data}, {32'h0, e});
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{16'h1111, 1'b1, 1'b0, 32'h0};
      vecs[1] = '{16'h2222, 1'b0, 1'b1, 32'h2222_1111};
      vecs[2] = '{16'hAAAA, 1'b1, 1'b0, 32'h0};
      vecs[3] = '{16'hBBBB, 1'b0, 1'b1, 32'hBBBB_AAAA};
      vecs[4] = '{16'hCCCC, 1'b0, 1'b0, 32'h0};
      vecs[5] = '{16'hDDDD, 1'b1, 1'b1, 32'h0000_CCCC};
      vecs[6] = '{16'hEEEE, 1'b0, 1'b1, 32'hEEEE_DDDD};

      sel = 1'b0;
      in_data = '0; in_wen = 1'b0; in_sof = 1'b0; stop_req = 1'b0; user_r_rden = 1'b0;
      do_reset();

      chk("rst_empty", 64'(m_empty), 64'd1);
      chk("rst_data",  64'(m_data),  64'd0);
      chk("rst_eof",   64'(m_eof),   64'd0);
      chk("rst_level", 64'(m_level), 64'd0);
      chk("rst_ovf",   64'(m_ovf),   64'd0);
      chk("rst_drop",  64'(m_drop),  64'd0);

      // basic two-sample word and its latency
      send(16'hAAAA, 1'b1);
      exp_q.push_back(32'hBBBB_AAAA);
      send(16'hBBBB, 1'b0);
      chk("s1_empty_c1", 64'(m_empty), 64'd1);
      tick();
      chk("s1_empty_c2", 64'(m_empty), 64'd0);
      chk("s1_level1",   64'(m_level), 64'd1);
      rd_one("s1_word");
      chk("s1_level0",   64'(m_level), 64'd0);
      chk("s1_empty_rd", 64'(m_empty), 64'd1);

      // table: back-to-back samples with SOF flushes
      for (int i = 0; i < 7; i++) begin
         in_data = vecs[i].data;
         in_sof  = vecs[i].sof;
         in_wen  = 1'b1;
         if (vecs[i].push) exp_q.push_back(vecs[i].word);
         tick();
      end
      in_wen = 1'b0;
      in_sof = 1'b0;
      for (int i = 0; i < 4; i++) rd_one("s2_word");
      chk("s2_level0", 64'(m_level), 64'd0);

      // frame-drop overflow policy
      do_reset();
      for (int k = 1; k <= 5; k++) send_word(k, (k == 1), (k <= 4));
      tick(); tick();
      chk("s3_ovf",   64'(m_ovf),   64'd1);
      chk("s3_drop1", 64'(m_drop),  64'd1);
      chk("s3_full",  64'(m_level), 64'd4);
      send_word(6, 1'b0, 1'b0);
      send_word(7, 1'b0, 1'b0);
      tick(); tick();
      chk("s3_drop3", 64'(m_drop), 64'd3);
      for (int i = 0; i < 4; i++) rd_one("s3_drain");
      send_word(8, 1'b1, 1'b1);
      rd_one("s3_after_sof");
      chk("s3_drop3b", 64'(m_drop), 64'd3);

      // word-drop overflow policy
      sel = 1'b1;
      do_reset();
      for (int k = 1; k <= 5; k++) send_word(k, (k == 1), (k <= 4));
      tick(); tick();
      chk("s4_ovf",   64'(n_ovf),   64'd1);
      chk("s4_drop1", 64'(n_drop),  64'd1);
      rd_one("s4_first");
      send_word(6, 1'b0, 1'b1);
      tick(); tick();
      chk("s4_drop1b", 64'(n_drop),  64'd1);
      chk("s4_level4", 64'(n_level), 64'd4);
      for (int i = 0; i < 4; i++) rd_one("s4_drain");

      // saturating drop counter (2-bit counter instance)
      do_reset();
      for (int k = 1; k <= 7; k++) send_word(k, (k == 1), 1'b0);
      tick(); tick();
      chk("sat_drop3", 64'(n_drop), 64'd3);
      send_word(8, 1'b0, 1'b0);
      send_word(9, 1'b0, 1'b0);
      tick(); tick();
      chk("sat_hold", 64'(n_drop), 64'd3);
      sel = 1'b0;

      // stop sequence: pad partial, ignore same-cycle and later samples, then EOF
      do_reset();
      send(16'h1234, 1'b1);
      in_data = 16'h9999; in_wen = 1'b1; stop_req = 1'b1;
      exp_q.push_back(32'h0000_1234);
      tick();
      in_wen = 1'b0; stop_req = 1'b0;
      tick();
      chk("s5_eof_pending", 64'(m_eof),   64'd0);
      chk("s5_level1",      64'(m_level), 64'd1);
      send(16'h7777, 1'b0);
      rd_one("s5_padded");
      tick(); tick();
      chk("s5_eof",   64'(m_eof),   64'd1);
      chk("s5_empty", 64'(m_empty), 64'd1);
      user_r_rden = 1'b1;
      tick();
      user_r_rden = 1'b0;
      chk("s5_data_hold", 64'(m_data), 64'h0000_1234);
      send(16'h5555, 1'b1);
      tick(); tick(); tick();
      chk("s5_eof_persist",   64'(m_eof),   64'd1);
      chk("s5_empty_persist", 64'(m_empty), 64'd1);
      chk("s5_level_persist", 64'(m_level), 64'd0);

      // close mid-stream keeps sticky status, reset clears it
      do_reset();
      for (int k = 1; k <= 5; k++) send_word(k, (k == 1), (k <= 4));
      tick(); tick();
      rd_one("s6_first");
      chk("s6_level3", 64'(m_level), 64'd3);
      chk("s6_ovf",    64'(m_ovf),   64'd1);
      user_r_open = 1'b0;
      tick();
      exp_q.delete();
      chk("s6_close_level", 64'(m_level), 64'd0);
      chk("s6_close_empty", 64'(m_empty), 64'd1);
      chk("s6_close_ovf",   64'(m_ovf),   64'd1);
      chk("s6_close_drop",  64'(m_drop),  64'd1);
      do_reset();
      chk("s6_rst_ovf",  64'(m_ovf),  64'd0);
      chk("s6_rst_drop", 64'(m_drop), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
